// File: rtl/iob_split_wd_pkg.sv
// Shared FSM states, bus widths and field offsets for the iob_split_wd splitter.
// Request layout {valid, addr, wdata, wstrb}; response layout {rdata, ready}.
package iob_split_wd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam int WSTRB_LSB = 0;
    localparam int READY_POS = 0;
    localparam int RDATA_LSB = 1;

    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_width(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int wdata_lsb(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int valid_pos(input int addr_w, input int data_w);
        return req_width(addr_w, data_w) - 1;
    endfunction

    function automatic int sel_width(input int n_slaves);
        return (n_slaves > 1) ? $clog2(n_slaves) : 1;
    endfunction

endpackage

// File: rtl/iob_split_wd_timer.sv
// Watchdog counter for one outstanding transaction; expired flags the last
// allowed BUSY cycle (count == TIMEOUT-1). Built only with IOB_SPLIT_WD_TIMEOUT_EN.
module iob_split_wd_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign expired = enable && (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/iob_split_wd.sv
// IOb native-bus 1:N splitter with error responses for unmapped slaves and,
// when IOB_SPLIT_WD_TIMEOUT_EN is defined, a per-transaction watchdog with dead_mask.
module iob_split_wd
    import iob_split_wd_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 2,
    parameter int P_SLAVES = ADDR_W - 2,
    parameter int SEL_W    = sel_width(N_SLAVES),
    parameter int TIMEOUT  = 1023,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF),
    localparam int REQ_W   = req_width(ADDR_W, DATA_W),
    localparam int RESP_W  = resp_width(DATA_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_W-1:0]           m_req,
    output logic [RESP_W-1:0]          m_resp,
    output logic [N_SLAVES*REQ_W-1:0]  s_req,
    input  logic [N_SLAVES*RESP_W-1:0] s_resp,
    output logic                       err,
    input  logic                       err_clr,
    output logic [N_SLAVES-1:0]        dead_mask
);

    localparam int VALID_POS = valid_pos(ADDR_W, DATA_W);
    localparam int ADDR_LSB  = addr_lsb(DATA_W);
    localparam int N_IDX     = 2 ** SEL_W;

    state_t            state_reg, state_next;
    logic [SEL_W-1:0]  sel_q_reg, sel_q_next;
    logic              err_reg;

    logic              m_valid;
    logic [SEL_W-1:0]  sel;
    logic              mapped;
    logic [RESP_W-1:0] resp_arr [N_IDX];
    logic [N_IDX-1:0]  dead_pad;

    logic              fwd_en;
    logic [SEL_W-1:0]  fwd_idx;
    logic [N_SLAVES-1:0] slave_valid;
    logic [RESP_W-1:0] m_resp_c;

    logic              timer_en;
    logic              timer_clr;
    logic              expired;
    logic              dead_set;

    genvar gi;

    assign m_valid = m_req[VALID_POS];
    assign sel     = m_req[ADDR_LSB + P_SLAVES -: SEL_W];
    assign mapped  = int'(sel) < N_SLAVES;

    // Pad responses and dead flags to a power of two so every select value indexes safely.
    for (gi = 0; gi < N_IDX; gi++) begin : g_idx
        if (gi < N_SLAVES) begin : g_map
            assign resp_arr[gi] = s_resp[gi*RESP_W +: RESP_W];
            assign dead_pad[gi] = dead_mask[gi];
        end else begin : g_unmap
            assign resp_arr[gi] = '0;
            assign dead_pad[gi] = 1'b0;
        end
    end

    for (gi = 0; gi < N_SLAVES; gi++) begin : g_slave
        assign slave_valid[gi] = fwd_en && (fwd_idx == SEL_W'(gi));
        assign s_req[gi*REQ_W +: REQ_W] = {slave_valid[gi], m_req[REQ_W-2:0]};
    end

    always_comb begin
        state_next = state_reg;
        sel_q_next = sel_q_reg;
        fwd_en     = 1'b0;
        fwd_idx    = sel_q_reg;
        m_resp_c   = '0;
        timer_en   = 1'b0;
        timer_clr  = 1'b0;
        dead_set   = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (m_valid) begin
                    if (mapped && !dead_pad[sel]) begin
                        fwd_en     = 1'b1;
                        fwd_idx    = sel;
                        sel_q_next = sel;
                        m_resp_c   = resp_arr[sel];
                        if (!resp_arr[sel][READY_POS]) begin
                            state_next = ST_BUSY;
                        end
                    end else begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_BUSY: begin
                // Routing follows the captured index even if the master's address moves.
                fwd_en   = 1'b1;
                m_resp_c = resp_arr[sel_q_reg];
                timer_en = 1'b1;
                if (resp_arr[sel_q_reg][READY_POS]) begin
                    state_next = ST_IDLE;
                    timer_clr  = 1'b1;
                end else if (expired) begin
                    state_next = ST_ERR;
                    timer_clr  = 1'b1;
                    dead_set   = 1'b1;
                end
            end
            ST_ERR: begin
                m_resp_c   = {ERR_DATA, 1'b1};
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // While reset is held nothing reaches either side, even with valid/ready high.
        if (rst) begin
            fwd_en   = 1'b0;
            m_resp_c = '0;
        end
    end

    assign m_resp = m_resp_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            sel_q_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_q_reg <= sel_q_next;
            if (state_next == ST_ERR) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign err = err_reg;

`ifdef IOB_SPLIT_WD_TIMEOUT_EN
    logic [N_SLAVES-1:0] dead_reg;
    logic [N_SLAVES-1:0] dead_hit;

    iob_split_wd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (expired)
    );

    for (gi = 0; gi < N_SLAVES; gi++) begin : g_dead
        assign dead_hit[gi] = dead_set && (sel_q_reg == SEL_W'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dead_reg <= '0;
        end else begin
            dead_reg <= dead_reg | dead_hit;
        end
    end

    assign dead_mask = dead_reg;
`else
    logic unused_timer;

    assign expired      = 1'b0;
    assign dead_mask    = '0;
    assign unused_timer = ^{timer_en, timer_clr, dead_set};
`endif

endmodule
